iir_out_requant: RTL and testbench



---
 rtl/iir_out_requant.sv | 178 +++++++++++++++++
 tb/tb_iir_out_requant.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_out_requant.sv
// iir_out_requant: requantises 32-bit signed IIR filter output samples to
// 16-bit signed samples. It shifts right arithmetically, optionally rounds,
// and saturates. Results are queued in a small show-ahead FIFO behind a
// valid/ready output. Sticky statistics count saturations and the samples
// dropped on overflow.
// Build option: define IIR_OUT_ROUND_EN to round half toward +infinity.
// Without it the stage truncates toward -infinity.
module iir_out_requant #(
    parameter int SHIFT = 12,   // fractional bits removed, 1..16
    parameter int DEPTH = 8     // FIFO depth, power of two, 2..64
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        full,
    input  logic        clr_stats,
    output logic        sat_flag,
    output logic [15:0] sat_count,
    output logic [7:0]  drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

`ifdef IIR_OUT_ROUND_EN
    localparam logic signed [32:0] ROUND_ADD = 33'sd1 <<< (SHIFT - 1);
`else
    localparam logic signed [32:0] ROUND_ADD = 33'sd0;
`endif
    localparam logic signed [32:0] Q_MAX = 33'sd32767;
    localparam logic signed [32:0] Q_MIN = -33'sd32768;

    // Stage-1 quantiser
    logic signed [32:0] w_t;
    logic signed [32:0] w_q;
    logic [15:0]        w_q_data;
    logic               w_q_sat;

    logic               r_s1_valid;
    logic [15:0]        r_s1_data;
    logic               r_s1_sat;

    // FIFO state
    logic [15:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_out_valid;
    logic [15:0]        r_out_data;
    logic               r_full;

    // Statistics
    logic               r_sat_flag;
    logic [15:0]        r_sat_count;
    logic [7:0]         r_drop_count;

    // FIFO control
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [CNT_W-1:0]   w_count_next;
    logic [CNT_W-1:0]   w_count_after_pop;
    logic [PTR_W-1:0]   w_rd_ptr_next;
    logic               w_bypass;
    logic [15:0]        w_head_next;

    // The 33-bit sum cannot overflow: |in_data| < 2^31 and the rounding term is <= 2^15
    assign w_t = $signed({in_data[31], in_data}) + ROUND_ADD;
    assign w_q = w_t >>> SHIFT;

    // Clamp the shifted value into the 16-bit signed range and flag clamping
    always_comb begin
        w_q_data = w_q[15:0];
        w_q_sat  = 1'b0;
        if (w_q > Q_MAX) begin
            w_q_data = 16'h7FFF;
            w_q_sat  = 1'b1;
        end else if (w_q < Q_MIN) begin
            w_q_data = 16'h8000;
            w_q_sat  = 1'b1;
        end
    end

    // Stage-1 register: accepts a new sample every cycle, valid follows the strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_sat   <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= w_q_data;
                r_s1_sat  <= w_q_sat;
            end
        end
    end

    // A write is allowed when there is room, or when the head leaves in the same cycle
    assign w_pop  = r_out_valid & out_ready;
    assign w_push = r_s1_valid & ((r_count < DEPTH_CNT) | w_pop);
    assign w_drop = r_s1_valid & ~w_push;

    assign w_count_after_pop = r_count - CNT_W'(w_pop);
    assign w_count_next      = w_count_after_pop + CNT_W'(w_push);
    assign w_rd_ptr_next     = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

    // When the FIFO drains to empty in this cycle, the sample being written becomes the new head.
    // Otherwise the new head is already in the array, at an address the write cannot touch this cycle.
    assign w_bypass    = w_push & (w_count_after_pop == '0);
    assign w_head_next = w_bypass ? r_s1_data : r_mem[w_rd_ptr_next];

    // Sample storage; contents need no reset because occupancy qualifies every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_s1_data;
        end
    end

    // Pointers, occupancy, and the registered show-ahead head/valid/full outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_full      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_out_valid <= (w_count_next != '0);
            r_full      <= (w_count_next == DEPTH_CNT);
            if (w_count_next != '0) begin
                r_out_data <= w_head_next;
            end
        end
    end

    // Sticky statistics; a clear wins over any event in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sat_flag   <= 1'b0;
            r_sat_count  <= '0;
            r_drop_count <= '0;
        end else if (clr_stats) begin
            r_sat_flag   <= 1'b0;
            r_sat_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (r_s1_valid && r_s1_sat) begin
                r_sat_flag <= 1'b1;
                if (r_sat_count != 16'hFFFF) begin
                    r_sat_count <= r_sat_count + 16'd1;
                end
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign full       = r_full;
    assign sat_flag   = r_sat_flag;
    assign sat_count  = r_sat_count;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_iir_out_requant.sv
// Testbench for iir_out_requant. A behavioural model (quantise by floor
// division, queue FIFO, saturating counters) is compared against the design
// on every falling edge. Directed vectors add hand-computed literal
// expectations.
module tb_iir_out_requant;

    localparam int SHIFT = 12;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        clr_stats = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        full;
    logic        sat_flag;
    logic [15:0] sat_count;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    iir_out_requant #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .full       (full),
        .clr_stats  (clr_stats),
        .sat_flag   (sat_flag),
        .sat_count  (sat_count),
        .drop_count (drop_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requantise from the arithmetic definition: floor(x / 2^SHIFT), optionally rounded, then clamped
    function automatic int quant(input logic [31:0] d, output bit sat);
        longint v;
        longint dv;
        longint q;
        v  = longint'($signed(d));
        dv = longint'(1) << SHIFT;
`ifdef IIR_OUT_ROUND_EN
        v = v + dv / 2;
`endif
        if (v >= 0) q = v / dv;
        else        q = -((-v + dv - 1) / dv);
        sat = 1'b0;
        if (q > 32767) begin
            q = 32767;
            sat = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            sat = 1'b1;
        end
        return int'(q);
    endfunction

    // Model state
    bit m_s1_valid = 0;
    bit m_s1_sat   = 0;
    int m_s1_val   = 0;
    int m_q[$];
    bit m_flag     = 0;
    int m_sat_cnt  = 0;
    int m_drop_cnt = 0;
    bit mp_pop, mp_push, mp_sat;

    // Model update at every clock edge or reset assertion
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_s1_valid = 0;
                m_s1_sat   = 0;
                m_q.delete();
                m_flag     = 0;
                m_sat_cnt  = 0;
                m_drop_cnt = 0;
            end else begin
                mp_pop  = (m_q.size() != 0) && out_ready;
                mp_push = m_s1_valid && ((m_q.size() < DEPTH) || mp_pop);
                if (mp_pop) void'(m_q.pop_front());
                if (mp_push) m_q.push_back(m_s1_val);
                if (clr_stats) begin
                    m_flag     = 0;
                    m_sat_cnt  = 0;
                    m_drop_cnt = 0;
                end else begin
                    if (m_s1_valid && m_s1_sat) begin
                        m_flag = 1;
                        if (m_sat_cnt < 65535) m_sat_cnt++;
                    end
                    if (m_s1_valid && !mp_push && m_drop_cnt < 255) m_drop_cnt++;
                end
                m_s1_valid = in_valid;
                if (in_valid) begin
                    m_s1_val = quant(in_data, mp_sat);
                    m_s1_sat = mp_sat;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            chk("m_out_valid", out_valid, int'(m_q.size() != 0));
            if (out_valid && m_q.size() != 0) chk("m_out_data", $signed(out_data), m_q[0]);
            chk("m_full", full, int'(m_q.size() == DEPTH));
            chk("m_sat_flag", sat_flag, int'(m_flag));
            chk("m_sat_count", sat_count, m_sat_cnt);
            chk("m_drop_count", drop_count, m_drop_cnt);
        end
    end

    // Strobe one sample into an empty, drained FIFO and check the two-cycle latency
    task automatic strobe_lat(input logic [31:0] d, input int exp, input string nm);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, "_early"}, out_valid, 0);
        @(negedge clk);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_data"}, $signed(out_data), exp);
        $display("txn %s: in=0x%08h out=%0d", nm, d, $signed(out_data));
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", $signed(out_data), 0);
        chk("rst_full", full, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_drop_count", drop_count, 0);
        rst = 1'b1;
        out_ready = 1'b1;

        // Rounding / truncation of +-1.5
`ifdef IIR_OUT_ROUND_EN
        strobe_lat(32'd6144, 2, "pos_1p5");
        strobe_lat(-32'sd6144, -1, "neg_1p5");
`else
        strobe_lat(32'd6144, 1, "pos_1p5");
        strobe_lat(-32'sd6144, -2, "neg_1p5");
`endif

        // Saturation and stats clear
        strobe_lat(32'h0800_0000, 32767, "sat_pos");
        strobe_lat(32'hF000_0000, -32768, "sat_neg");
        chk("sat_count_2", sat_count, 2);
        chk("sat_flag_1", sat_flag, 1);
        pulse_clr();
        chk("clr_sat_count", sat_count, 0);
        chk("clr_sat_flag", sat_flag, 0);
        chk("clr_drop_count", drop_count, 0);

        // Clear in the same cycle as a saturated write: not counted
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h0800_0000;
        @(negedge clk);
        in_valid  = 1'b0;
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        chk("prio_data", $signed(out_data), 32767);
        chk("prio_sat_count", sat_count, 0);
        chk("prio_sat_flag", sat_flag, 0);
        @(negedge clk);

        // Overflow: 10 strobes into a stalled depth-8 FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("ovf_full", full, int'(i >= 9));
            in_valid = 1'b1;
            in_data  = 32'((i + 1) * 4096);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("ovf_drop_1", drop_count, 1);
        @(negedge clk);
        chk("ovf_drop_2", drop_count, 2);
        chk("ovf_full_hold", full, 1);
        chk("ovf_head", $signed(out_data), 1);
        out_ready = 1'b1;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) chk("ovf_full_fall", full, 0);
            chk("ovf_drain", $signed(out_data), k);
            $display("txn drain: out=%0d", $signed(out_data));
        end
        @(negedge clk);
        chk("ovf_empty", out_valid, 0);

        // Full FIFO streaming: push and pop every cycle across pointer wrap
        pulse_clr();
        chk("stream_drop_clr", drop_count, 0);
        out_ready = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (j == 9) out_ready = 1'b1;
            if (j >= 9) begin
                chk("stream_full", full, 1);
                chk("stream_data", $signed(out_data), 20 + j - 9);
                chk("stream_drop", drop_count, 0);
                $display("txn stream: out=%0d", $signed(out_data));
            end
            in_valid = 1'b1;
            in_data  = 32'((j + 20) * 4096);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int e = 31; e <= 39; e++) begin
            chk("stream_tail", $signed(out_data), e);
            $display("txn tail: out=%0d", $signed(out_data));
            @(negedge clk);
        end
        chk("stream_empty", out_valid, 0);

        // Asynchronous reset mid-burst with 5 samples queued
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = (i == 0) ? 32'h0800_0000 : 32'(i * 4096);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_sat", sat_count, 1);
        chk("pre_rst_full", full, 0);
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", $signed(out_data), 0);
        chk("arst_full", full, 0);
        chk("arst_sat_flag", sat_flag, 0);
        chk("arst_sat_count", sat_count, 0);
        chk("arst_drop_count", drop_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        strobe_lat(32'd28672, 7, "post_rst");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
